ef_sram_responder: RTL

//  Responder (memory side) of the EF_SRAM fabric tile interface.

---
 rtl/ef_sram_responder_if.sv | 23 ++
 rtl/ef_sram_responder.sv | 83 ++++++++
 2 files changed

// File: rtl/ef_sram_responder_if.sv
// EF_SRAM tile request/response bus: one request per cycle, DO returns a cycle later.
// The tile side uses the master modport and the memory side uses the slave modport.
interface ef_sram_responder_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic          EN_SRAM;
    logic          R_WB_SRAM;
    logic [AW-1:0] AD_SRAM;
    logic [DW-1:0] BEN_SRAM;
    logic [DW-1:0] DI_SRAM;
    logic [DW-1:0] DO_SRAM;

    modport master (
        output EN_SRAM, R_WB_SRAM, AD_SRAM, BEN_SRAM, DI_SRAM,
        input  DO_SRAM
    );

    modport slave (
        input  EN_SRAM, R_WB_SRAM, AD_SRAM, BEN_SRAM, DI_SRAM,
        output DO_SRAM
    );
endinterface

// File: rtl/ef_sram_responder.sv
// EF_SRAM responder: bit-masked single-port word store with a sweep-to-clear FSM.
// Latency: read data on DO_SRAM one cycle after the request; writes land at the request edge.
// Backpressure: none; requests seen while busy are dropped and counted in drop_cnt.
module ef_sram_responder #(
    parameter int             AW         = 10,
    parameter int             DW         = 32,
    parameter logic [DW-1:0]  INIT_VALUE = '0,
    parameter int             CNT_W      = 8
) (
    input  logic               UserCLK,
    input  logic               RESETn,
    ef_sram_responder_if.slave bus,
    input  logic               clear_req,
    output logic               busy,
    output logic [CNT_W-1:0]   drop_cnt
);
    localparam int            DEPTH    = 2 ** AW;
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t        state;
    logic [AW-1:0] ptr;
    logic [DW-1:0] do_q;
    logic [DW-1:0] mem [DEPTH];

    logic          mem_we;
    logic [AW-1:0] mem_wa;
    logic [DW-1:0] mem_wd;

    // Single write port shared by the sweep and masked user writes.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = ptr;
        mem_wd = INIT_VALUE;
        if (state == ST_CLEAR) begin
            mem_we = 1'b1;
        end else if (bus.EN_SRAM && !bus.R_WB_SRAM) begin
            mem_we = 1'b1;
            mem_wa = bus.AD_SRAM;
            mem_wd = (mem[bus.AD_SRAM] & ~bus.BEN_SRAM) | (bus.DI_SRAM & bus.BEN_SRAM);
        end
    end

    // Array is deliberately unreset; the sweep after reset initialises it.
    always_ff @(posedge UserCLK) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    always_ff @(posedge UserCLK or negedge RESETn) begin
        if (!RESETn) begin
            state    <= ST_CLEAR;
            busy     <= 1'b1;
            ptr      <= '0;
            drop_cnt <= '0;
            do_q     <= '0;
        end else if (state == ST_CLEAR) begin
            if (bus.EN_SRAM && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
            if (ptr == PTR_LAST) begin
                state <= ST_READY;
                busy  <= 1'b0;
                ptr   <= '0;
            end else begin
                ptr <= ptr + 1'b1;
            end
        end else begin
            if (bus.EN_SRAM && bus.R_WB_SRAM) begin
                do_q <= mem[bus.AD_SRAM];
            end
            // The request presented with clear_req is still served above.
            if (clear_req) begin
                state <= ST_CLEAR;
                busy  <= 1'b1;
            end
        end
    end

    assign bus.DO_SRAM = do_q;
endmodule
